// File: rtl/memory_fabric_if.sv
// Consumer-side bus of memory_fabric; port i owns slice i of every vector.
// Handshake: a dispatch_read/dispatch_write pulse is accepted on an edge where busy[i] is low (read wins if both are high). busy[i] then stays high up to and including the completing edge, and after a read rdata[i] holds the result from the moment busy[i] falls until port i's next read completes.
interface memory_fabric_if #(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 32
);
   logic [NUM_PORTS*ADDR_W-1:0] addr;
   logic [NUM_PORTS*DATA_W-1:0] wdata;
   logic [NUM_PORTS-1:0]        dispatch_read;
   logic [NUM_PORTS-1:0]        dispatch_write;
   logic [NUM_PORTS*DATA_W-1:0] rdata;
   logic [NUM_PORTS-1:0]        busy;

   modport master (output addr, wdata, dispatch_read, dispatch_write, input rdata, busy);
   modport slave  (input addr, wdata, dispatch_read, dispatch_write, output rdata, busy);
endinterface

// File: rtl/memory_fabric.sv
// Multi-port fabric that serialises consumer requests onto a RAM, a frame buffer and an IO window.
// Define MEM_FABRIC_FIXED_PRIORITY_EN to replace round-robin arbitration with fixed lowest-index priority.
module memory_fabric #(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 32,
   parameter int RAM_AW    = 16,
   parameter int RAM_LAT   = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   memory_fabric_if.slave     bus,
   output logic [RAM_AW-1:0]  ram_addr,
   output logic [DATA_W-1:0]  ram_wdata,
   output logic               ram_we,
   input  logic [DATA_W-1:0]  ram_rdata,
   output logic [15:0]        fb_addr,
   output logic [DATA_W-1:0]  fb_wdata,
   output logic               fb_we,
   output logic [7:0]         io_offset,
   input  logic [DATA_W-1:0]  io_rdata,
   output logic [1:0]         o_dbg_state,
   output logic [2:0]         o_dbg_grant
);
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACCESS   = 2'd1,
      S_RAM_WAIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [NUM_PORTS-1:0] r_pending;
   logic [NUM_PORTS-1:0] r_req_read;
   logic [ADDR_W-1:0]   r_req_addr  [NUM_PORTS];
   logic [DATA_W-1:0]   r_req_wdata [NUM_PORTS];
   logic [DATA_W-1:0]   r_rdata     [NUM_PORTS];
   logic [ADDR_W-1:0]   r_svc_addr;
   logic [DATA_W-1:0]   r_svc_wdata;
   logic                r_svc_read;
   logic [GW-1:0]       r_svc_port;
   logic [GW-1:0]       r_last_grant;
   logic [2:0]          r_wait_cnt;

   logic                w_grant_valid;
   logic [GW-1:0]       w_grant_idx;
   logic                w_grant_en;
   logic                w_done;
   logic                w_is_io;
   logic                w_is_fb;
   logic                w_is_ram;
   logic [DATA_W-1:0]   w_rd_value;

   // Decode always looks at the service register, so targets stay stable for the whole access.
   assign w_is_io  = &r_svc_addr[ADDR_W-1:8];
   assign w_is_fb  = !w_is_io && (r_svc_addr[ADDR_W-1:16] == '0);
   assign w_is_ram = !w_is_io && !w_is_fb;

   assign ram_addr    = r_svc_addr[RAM_AW-1:0];
   assign ram_wdata   = r_svc_wdata;
   assign fb_addr     = r_svc_addr[15:0];
   assign fb_wdata    = r_svc_wdata;
   assign io_offset   = r_svc_addr[7:0];
   assign o_dbg_state = r_state;
   assign o_dbg_grant = 3'(r_svc_port);
   assign bus.busy    = r_pending;

   always_comb begin
      bus.rdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         bus.rdata[i*DATA_W +: DATA_W] = r_rdata[i];
      end
   end

   assign w_rd_value = w_is_io ? io_rdata : (w_is_fb ? '0 : ram_rdata);

   always_comb begin : arb
      logic          hi_valid;
      logic [GW-1:0] hi_idx;
      hi_valid      = 1'b0;
      hi_idx        = '0;
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
`ifdef MEM_FABRIC_FIXED_PRIORITY_EN
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (r_pending[k]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = GW'(k);
         end
      end
`else
      // Lowest pending index above last_grant wins; otherwise wrap to the lowest pending index.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (r_pending[k]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = GW'(k);
            if (k > int'(r_last_grant)) begin
               hi_valid = 1'b1;
               hi_idx   = GW'(k);
            end
         end
      end
      if (hi_valid) begin
         w_grant_idx = hi_idx;
      end
`endif
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_grant_en = 1'b0;
      w_done     = 1'b0;
      ram_we     = 1'b0;
      fb_we      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant_valid) begin
               w_grant_en = 1'b1;
               w_next     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            ram_we = !r_svc_read && w_is_ram;
            fb_we  = !r_svc_read && w_is_fb;
            if (r_svc_read && w_is_ram && (RAM_LAT > 1)) begin
               w_next = S_RAM_WAIT;
            end else begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         S_RAM_WAIT: begin
            // r_wait_cnt counts cycles since ACCESS entry; the next edge brings it to RAM_LAT.
            if (r_wait_cnt == 3'(RAM_LAT - 1)) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_pending    <= '0;
         r_req_read   <= '0;
         r_svc_addr   <= '0;
         r_svc_wdata  <= '0;
         r_svc_read   <= 1'b0;
         r_svc_port   <= '0;
         r_last_grant <= GW'(NUM_PORTS - 1);
         r_wait_cnt   <= 3'd0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_req_addr[i]  <= '0;
            r_req_wdata[i] <= '0;
            r_rdata[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!r_pending[i] && (bus.dispatch_read[i] || bus.dispatch_write[i])) begin
               r_pending[i]   <= 1'b1;
               r_req_read[i]  <= bus.dispatch_read[i];
               r_req_addr[i]  <= bus.addr[i*ADDR_W +: ADDR_W];
               r_req_wdata[i] <= bus.wdata[i*DATA_W +: DATA_W];
            end
         end
         if (w_grant_en) begin
            r_svc_addr   <= r_req_addr[w_grant_idx];
            r_svc_wdata  <= r_req_wdata[w_grant_idx];
            r_svc_read   <= r_req_read[w_grant_idx];
            r_svc_port   <= w_grant_idx;
            r_last_grant <= w_grant_idx;
         end
         if (w_done) begin
            r_pending[r_svc_port] <= 1'b0;
            if (r_svc_read) begin
               r_rdata[r_svc_port] <= w_rd_value;
            end
         end
         case (r_state)
            S_ACCESS:   r_wait_cnt <= 3'd1;
            S_RAM_WAIT: r_wait_cnt <= r_wait_cnt + 3'd1;
            default:    r_wait_cnt <= 3'd0;
         endcase
      end
   end
endmodule
